// File: rtl/dcpu16_opr.sv
// Operand fetch / effective-address stage for a DCPU-16 pipeline.
// Resolves one 6-bit operand field per enabled cycle into operand A or B,
// owns the stack pointer, and issues single data-bus reads for memory modes.
module dcpu16_opr #(
  parameter logic [15:0] SP_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        pha,
  input  logic [5:0]  ea,
  input  logic [15:0] rrd,
  input  logic [15:0] nwd,
  input  logic [15:0] regpc,
  input  logic [15:0] rego,
  input  logic [15:0] ab_dti,
  input  logic        ab_ack,
  output logic [15:0] ab_adr,
  output logic        ab_ena,
  output logic [15:0] opa,
  output logic [15:0] opb,
  output logic        nwc,
  output logic [15:0] sp
);

  // Decoded action for the current operand field.
  logic        dec_wr;   // write dec_val straight into the target operand
  logic [15:0] dec_val;
  logic        dec_mem;  // start a bus read at dec_adr
  logic [15:0] dec_adr;
  logic        dec_nw;   // consumes the next instruction word
  logic [15:0] dec_sp;   // stack pointer after this decode

  // Remembers which operand the outstanding bus read will land in.
  logic        tgt_a;

  // Addressing-mode decode of ea into value/address/side effects.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned; otherwise synthesis infers a latch.
    dec_wr  = 1'b0;
    dec_val = 16'h0000;
    dec_mem = 1'b0;
    dec_adr = 16'h0000;
    dec_nw  = 1'b0;
    dec_sp  = sp;
    case (ea) inside
      [6'h00:6'h07]: begin
        dec_wr  = 1'b1;
        dec_val = rrd;
      end
      [6'h08:6'h0f]: begin
        dec_mem = 1'b1;
        dec_adr = rrd;
      end
      [6'h10:6'h17]: begin
        dec_mem = 1'b1;
        dec_adr = rrd + nwd;
        dec_nw  = 1'b1;
      end
      6'h18: begin                      // POP: read at sp, then increment
        dec_mem = 1'b1;
        dec_adr = sp;
        dec_sp  = sp + 16'd1;
      end
      6'h19: begin                      // PEEK
        dec_mem = 1'b1;
        dec_adr = sp;
      end
      6'h1a: begin                      // PUSH: decrement, access new sp
        dec_mem = 1'b1;
        dec_adr = sp - 16'd1;
        dec_sp  = sp - 16'd1;
      end
      6'h1b: begin
        dec_wr  = 1'b1;
        dec_val = sp;
      end
      6'h1c: begin
        dec_wr  = 1'b1;
        dec_val = regpc;
      end
      6'h1d: begin
        dec_wr  = 1'b1;
        dec_val = rego;
      end
      6'h1e: begin
        dec_mem = 1'b1;
        dec_adr = nwd;
        dec_nw  = 1'b1;
      end
      6'h1f: begin
        dec_wr  = 1'b1;
        dec_val = nwd;
        dec_nw  = 1'b1;
      end
      default: begin                    // 0x20-0x3f short literal 0..31
        dec_wr  = 1'b1;
        dec_val = {11'b0, ea[4:0]};
      end
    endcase
  end

  // Pipeline state: bus completion takes priority and ignores ena;
  // a new decode is accepted only with ena high and no read outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      ab_adr <= 16'h0000;
      ab_ena <= 1'b0;
      opa    <= 16'h0000;
      opb    <= 16'h0000;
      nwc    <= 1'b0;
      sp     <= SP_RST;
      tgt_a  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values; nwc defaults low to make a pulse.
      nwc <= 1'b0;
      if (ab_ena) begin
        if (ab_ack) begin
          if (tgt_a) opa <= ab_dti;
          else       opb <= ab_dti;
          ab_ena <= 1'b0;
        end
      end else if (ena) begin
        sp  <= dec_sp;
        nwc <= dec_nw;
        if (dec_wr) begin
          if (pha) opa <= dec_val;
          else     opb <= dec_val;
        end
        if (dec_mem) begin
          ab_adr <= dec_adr;
          ab_ena <= 1'b1;
          tgt_a  <= pha;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcpu16_opr.sv
// Self-checking bench for dcpu16_opr: table of single-cycle operand modes,
// directed bus/stack/reset sequences, then randomized operands against a
// behavioural model of the addressing rules.
module tb_dcpu16_opr;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        pha;
  logic [5:0]  ea;
  logic [15:0] rrd, nwd, regpc, rego, ab_dti;
  logic        ab_ack;
  logic [15:0] ab_adr, opa, opb, sp;
  logic        ab_ena, nwc;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state.
  logic [15:0] m_sp, m_opa, m_opb;

  dcpu16_opr #(.SP_RST(16'h0000)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pha(pha), .ea(ea), .rrd(rrd),
    .nwd(nwd), .regpc(regpc), .rego(rego), .ab_dti(ab_dti),
    .ab_ack(ab_ack), .ab_adr(ab_adr), .ab_ena(ab_ena), .opa(opa),
    .opb(opb), .nwc(nwc), .sp(sp)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the addressing rules.
  task automatic ref_decode(input logic [5:0] e, input logic [15:0] r,
                            input logic [15:0] w, input logic [15:0] pc,
                            input logic [15:0] o, input logic [15:0] s,
                            output bit mem, output logic [15:0] v,
                            output bit nw, output logic [15:0] s_next);
    int ei = int'(e);
    mem = 0; nw = 0; s_next = s; v = 16'h0;
    if (ei < 8)        v = r;
    else if (ei < 16)  begin mem = 1; v = r; end
    else if (ei < 24)  begin mem = 1; nw = 1; v = 16'((int'(r) + int'(w)) % 65536); end
    else if (ei == 24) begin mem = 1; v = s; s_next = 16'((int'(s) + 1) % 65536); end
    else if (ei == 25) begin mem = 1; v = s; end
    else if (ei == 26) begin mem = 1; s_next = 16'((int'(s) + 65535) % 65536); v = s_next; end
    else if (ei == 27) v = s;
    else if (ei == 28) v = pc;
    else if (ei == 29) v = o;
    else if (ei == 30) begin mem = 1; nw = 1; v = w; end
    else if (ei == 31) begin nw = 1; v = w; end
    else               v = 16'(ei - 32);
  endtask

  // One complete operand: decode, optional bus read with wait states.
  task automatic do_op(input logic [5:0] e, input logic p,
                       input logic [15:0] r, input logic [15:0] w,
                       input logic [15:0] pc, input logic [15:0] o,
                       input int waits, input logic [15:0] dti,
                       input bit poke_ena);
    bit mem, nw;
    logic [15:0] v, s_next;
    ref_decode(e, r, w, pc, o, m_sp, mem, v, nw, s_next);
    ea = e; pha = p; rrd = r; nwd = w; regpc = pc; rego = o; ena = 1'b1;
    step();
    ena = 1'b0; ea = 6'($urandom); rrd = 16'($urandom); nwd = 16'($urandom);
    m_sp = s_next;
    check("dec_nwc", nwc, nw);
    check("dec_sp", sp, m_sp);
    check("dec_ab_ena", ab_ena, mem);
    if (!mem) begin
      if (p) m_opa = v; else m_opb = v;
    end else begin
      check("dec_ab_adr", ab_adr, v);
      for (int i = 0; i < waits; i++) begin
        ena = poke_ena;        // a decode here must be ignored
        pha = ~p;
        step();
        ena = 1'b0;
        check("wait_ab_ena", ab_ena, 1'b1);
        check("wait_ab_adr", ab_adr, v);
        check("wait_sp", sp, m_sp);
        check("wait_nwc", nwc, 1'b0);
      end
      ab_ack = 1'b1; ab_dti = dti;
      step();
      ab_ack = 1'b0; ab_dti = 16'($urandom);
      check("ack_ab_ena", ab_ena, 1'b0);
      if (p) m_opa = dti; else m_opb = dti;
    end
    check("op_opa", opa, m_opa);
    check("op_opb", opb, m_opb);
    step();
    check("idle_nwc", nwc, 1'b0);
    check("idle_ab_ena", ab_ena, 1'b0);
  endtask

  typedef struct {
    logic [5:0]  ea;
    logic        pha;
    logic [15:0] rrd, nwd, pc, o;
    logic [15:0] exp_val;
    logic        exp_nwc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{6'h03, 1'b1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1'b0};
    vecs[1] = '{6'h07, 1'b0, 16'hABCD, 16'h1111, 16'h0000, 16'h0000, 16'hABCD, 1'b0};
    vecs[2] = '{6'h1b, 1'b1, 16'h9999, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{6'h1c, 1'b0, 16'h0000, 16'h0000, 16'h4321, 16'h0000, 16'h4321, 1'b0};
    vecs[4] = '{6'h1d, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 16'h00FF, 1'b0};
    vecs[5] = '{6'h3f, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h001F, 1'b0};
    vecs[6] = '{6'h1f, 1'b0, 16'h0000, 16'hA5A5, 16'h0000, 16'h0000, 16'hA5A5, 1'b1};
    vecs[7] = '{6'h20, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};

    rst = 1'b1; ena = 1'b0; pha = 1'b0; ea = 6'h0; rrd = 16'h0; nwd = 16'h0;
    regpc = 16'h0; rego = 16'h0; ab_dti = 16'h0; ab_ack = 1'b0;
    step(); step();
    check("rst_ab_adr", ab_adr, 16'h0000);
    check("rst_ab_ena", ab_ena, 1'b0);
    check("rst_opa", opa, 16'h0000);
    check("rst_opb", opb, 16'h0000);
    check("rst_nwc", nwc, 1'b0);
    check("rst_sp", sp, 16'h0000);
    rst = 1'b0;
    m_sp = 16'h0000; m_opa = 16'h0000; m_opb = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_sp", sp, 16'h0000);
      check("idle_ab_ena", ab_ena, 1'b0);
      check("idle_opa", opa, 16'h0000);
      check("idle_opb", opb, 16'h0000);
    end

    // Single-cycle modes from the table.
    for (int i = 0; i < 8; i++) begin
      ea = vecs[i].ea; pha = vecs[i].pha; rrd = vecs[i].rrd;
      nwd = vecs[i].nwd; regpc = vecs[i].pc; rego = vecs[i].o; ena = 1'b1;
      step();
      ena = 1'b0;
      if (vecs[i].pha) m_opa = vecs[i].exp_val; else m_opb = vecs[i].exp_val;
      check($sformatf("vec%0d_opa", i), opa, m_opa);
      check($sformatf("vec%0d_opb", i), opb, m_opb);
      check($sformatf("vec%0d_nwc", i), nwc, vecs[i].exp_nwc);
      check($sformatf("vec%0d_ab_ena", i), ab_ena, 1'b0);
      step();
      check($sformatf("vec%0d_nwc_pulse", i), nwc, 1'b0);
    end

    // [nw+reg] with three wait states, address wraps to 0x0008.
    ea = 6'h12; pha = 1'b0; rrd = 16'h0010; nwd = 16'hFFF8; ena = 1'b1;
    step();
    ena = 1'b0;
    check("nwr_ab_adr", ab_adr, 16'h0008);
    check("nwr_nwc", nwc, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("nwr_hold_ab_ena", ab_ena, 1'b1);
      check("nwr_hold_nwc", nwc, 1'b0);
      check("nwr_hold_opb", opb, m_opb);
    end
    ab_ack = 1'b1; ab_dti = 16'hBEEF;
    step();
    ab_ack = 1'b0;
    m_opb = 16'hBEEF;
    check("nwr_done_ab_ena", ab_ena, 1'b0);
    check("nwr_opb", opb, 16'hBEEF);
    step();

    // Stack wrap both ways; a stray decode during the PUSH wait is ignored.
    do_op(6'h1a, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 2, 16'h5555, 1'b1);
    check("push_wrap_sp", sp, 16'hFFFF);
    check("push_wrap_opa", opa, 16'h5555);
    do_op(6'h18, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h6666, 1'b0);
    check("pop_wrap_sp", sp, 16'h0000);
    check("pop_wrap_opb", opb, 16'h6666);

    // Acknowledge with no request pending must not touch operands.
    ab_ack = 1'b1; ab_dti = 16'hDEAD;
    step(); step();
    ab_ack = 1'b0;
    check("stray_ack_opa", opa, m_opa);
    check("stray_ack_opb", opb, m_opb);

    // Randomized operands against the model.
    for (int n = 0; n < 200; n++) begin
      do_op(6'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
            16'($urandom), 1'($urandom));
    end

    // Reset while a PEEK awaits acknowledge; a late ack is ignored.
    do_op(6'h1a, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h1357, 1'b0);
    ea = 6'h19; pha = 1'b1; ena = 1'b1;
    step();
    ena = 1'b0;
    check("pre_rst_ab_ena", ab_ena, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ab_ena", ab_ena, 1'b0);
    check("mid_rst_sp", sp, 16'h0000);
    ab_ack = 1'b1; ab_dti = 16'h7777;
    step();
    ab_ack = 1'b0;
    check("late_ack_opa", opa, 16'h0000);
    check("late_ack_opb", opb, 16'h0000);
    check("late_ack_ab_ena", ab_ena, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
